// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg
// Shared definitions for the SPI register-access controller (spi_reg_ctrl).
//
// Contents:
//   spi_reg_state_t        controller FSM state encoding
//   K_DWIDTH_DEFAULT       default SPI word width (must match spi_slave)
//   K_AWIDTH_DEFAULT       default register address width
//   K_READ_FLAG_BIT        read-flag bit position for the default word width
//   read_flag_pos()        read-flag bit position for any word width
// ---------------------------------------------------------------------------
package spi_reg_pkg;

   localparam int K_DWIDTH_DEFAULT = 16;
   localparam int K_AWIDTH_DEFAULT = 7;

   // The read flag is always the MSB of the command word.
   function automatic int read_flag_pos(input int dwidth);
      return dwidth - 1;
   endfunction

   localparam int K_READ_FLAG_BIT = K_DWIDTH_DEFAULT - 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CMD      = 3'd1,
      ST_RD_REQ   = 3'd2,
      ST_RD_SHIFT = 3'd3,
      ST_WR_DATA  = 3'd4,
      ST_NEXT     = 3'd5,
      ST_DONE     = 3'd6
   } spi_reg_state_t;

endpackage

// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
// Turns the word stream of spi_slave into register-bus accesses. Each
// chip-select frame starts with a command word (MSB = read flag, low
// K_AWIDTH bits = address) followed by data words. Writes take the data
// word from the host; reads fetch from the register bus and load the result
// into the slave's transmit path before the next word shifts out.
//
// Optional feature (macro SPI_REG_CTRL_AUTOINC_EN):
//   defined   - burst mode: after each data word the address increments
//               (wrapping at 2^K_AWIDTH) and another access of the same
//               direction follows.
//   undefined - exactly one access per frame; later words are ignored.
//
// Parameters:
//   K_DWIDTH      SPI word width
//   K_AWIDTH      register address width (K_AWIDTH <= K_DWIDTH-1)
//
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_spi_selected  registered chip select from spi_slave
//   i_rx_event      one-cycle pulse: word received
//   i_rx_data       received word, valid with i_rx_event
//   o_tx_data       word for the slave to shift out
//   o_tx_valid      one-cycle load strobe for o_tx_data
//   o_reg_addr      register bus address
//   o_reg_wdata     register bus write data
//   o_reg_we        one-cycle write strobe
//   o_reg_re        read request, held until i_reg_rvalid
//   i_reg_rdata     register bus read data
//   i_reg_rvalid    read acknowledge
//   o_late          one-cycle pulse: read data missed its word slot
// ---------------------------------------------------------------------------
module spi_reg_ctrl
   import spi_reg_pkg::*;
#(
   parameter int K_DWIDTH = K_DWIDTH_DEFAULT,
   parameter int K_AWIDTH = K_AWIDTH_DEFAULT
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_spi_selected,
   input  logic                i_rx_event,
   input  logic [K_DWIDTH-1:0] i_rx_data,
   output logic [K_DWIDTH-1:0] o_tx_data,
   output logic                o_tx_valid,
   output logic [K_AWIDTH-1:0] o_reg_addr,
   output logic [K_DWIDTH-1:0] o_reg_wdata,
   output logic                o_reg_we,
   output logic                o_reg_re,
   input  logic [K_DWIDTH-1:0] i_reg_rdata,
   input  logic                i_reg_rvalid,
   output logic                o_late
);

   localparam int READ_BIT = read_flag_pos(K_DWIDTH);

   spi_reg_state_t state;

`ifdef SPI_REG_CTRL_AUTOINC_EN
   // Remembers the frame direction so NEXT knows which access to repeat.
   logic read_mode;
`endif

   // Whole controller in one registered process: every output is a flop, so
   // there is no combinational path from any input to any output.
   // Deselect is checked first so it overrides a word or read acknowledge
   // arriving in the same cycle; the strobes default low, so an aborted
   // frame never produces a write or a transmit load.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         o_tx_data   <= '0;
         o_tx_valid  <= 1'b0;
         o_reg_addr  <= '0;
         o_reg_wdata <= '0;
         o_reg_we    <= 1'b0;
         o_reg_re    <= 1'b0;
         o_late      <= 1'b0;
`ifdef SPI_REG_CTRL_AUTOINC_EN
         read_mode   <= 1'b0;
`endif
      end else begin
         o_tx_valid <= 1'b0;
         o_reg_we   <= 1'b0;
         o_late     <= 1'b0;

         if (!i_spi_selected) begin
            state    <= ST_IDLE;
            o_reg_re <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_CMD;
               end

               // First word of the frame is the command.
               ST_CMD: begin
                  if (i_rx_event) begin
                     o_reg_addr <= i_rx_data[K_AWIDTH-1:0];
`ifdef SPI_REG_CTRL_AUTOINC_EN
                     read_mode  <= i_rx_data[READ_BIT];
`endif
                     if (i_rx_data[READ_BIT]) begin
                        o_reg_re <= 1'b1;
                        state    <= ST_RD_REQ;
                     end else begin
                        state    <= ST_WR_DATA;
                     end
                  end
               end

               // A word completing here means the host already clocked out
               // stale transmit data; flag it but keep waiting so the data
               // still reaches the slave once it arrives.
               ST_RD_REQ: begin
                  if (i_rx_event) begin
                     o_late <= 1'b1;
                  end
                  if (i_reg_rvalid) begin
                     o_tx_data  <= i_reg_rdata;
                     o_tx_valid <= 1'b1;
                     o_reg_re   <= 1'b0;
                     state      <= ST_RD_SHIFT;
                  end
               end

               // The host's word during a read is a dummy; only its end
               // matters.
               ST_RD_SHIFT: begin
                  if (i_rx_event) begin
                     state <= ST_NEXT;
                  end
               end

               ST_WR_DATA: begin
                  if (i_rx_event) begin
                     o_reg_wdata <= i_rx_data;
                     o_reg_we    <= 1'b1;
                     state       <= ST_NEXT;
                  end
               end

               // Burst mode steps the address (natural wrap at the top) and
               // repeats the access; otherwise the frame is finished.
               ST_NEXT: begin
`ifdef SPI_REG_CTRL_AUTOINC_EN
                  o_reg_addr <= o_reg_addr + K_AWIDTH'(1);
                  if (read_mode) begin
                     o_reg_re <= 1'b1;
                     state    <= ST_RD_REQ;
                  end else begin
                     state    <= ST_WR_DATA;
                  end
`else
                  state <= ST_DONE;
`endif
               end

               ST_DONE: begin
                  state <= ST_DONE;
               end

               default: begin
                  state    <= ST_IDLE;
                  o_reg_re <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_ctrl
// Self-checking bench for spi_reg_ctrl. Stimulus pushes expected register
// writes, transmit loads and late pulses into queues; a monitor on the
// falling clock edge pops and compares whenever the DUT strobes an output.
// Expectations for the burst case follow SPI_REG_CTRL_AUTOINC_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

   localparam int DW = 16;
   localparam int AW = 7;

   logic          clk;
   logic          rst_n;
   logic          spiSelected;
   logic          rxEvent;
   logic [DW-1:0] rxData;
   logic [DW-1:0] txData;
   logic          txValid;
   logic [AW-1:0] regAddr;
   logic [DW-1:0] regWdata;
   logic          regWe;
   logic          regRe;
   logic [DW-1:0] regRdata;
   logic          regRvalid;
   logic          late;

   int testsRun = 0;
   int testsFailed = 0;
   int reHighTotal = 0;

   logic [AW+DW-1:0] wrQ[$];
   logic [DW-1:0]    rdQ[$];
   bit               lateQ[$];

   spi_reg_ctrl #(.K_DWIDTH(DW), .K_AWIDTH(AW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_spi_selected (spiSelected),
      .i_rx_event     (rxEvent),
      .i_rx_data      (rxData),
      .o_tx_data      (txData),
      .o_tx_valid     (txValid),
      .o_reg_addr     (regAddr),
      .o_reg_wdata    (regWdata),
      .o_reg_we       (regWe),
      .o_reg_re       (regRe),
      .i_reg_rdata    (regRdata),
      .i_reg_rvalid   (regRvalid),
      .o_late         (late)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point shared by stimulus and monitor.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One SPI word: a single-cycle receive pulse, then an idle gap.
   task automatic applyStimulus(input logic [DW-1:0] word, input int gap);
      rxData  = word;
      rxEvent = 1'b1;
      @(posedge clk); #1;
      rxEvent = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic selectFrame();
      spiSelected = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic endFrame();
      spiSelected = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic waitForRe();
      int n = 0;
      while (!regRe && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("re_raised", {31'd0, regRe}, 32'd1);
   endtask

   // Monitor: every strobe must match the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (regRe) reHighTotal++;
         if (regWe) begin
            if (wrQ.size() == 0) begin
               checkOutput("we_unexpected", {31'd0, regWe}, 32'd0);
            end else begin
               logic [AW+DW-1:0] exp;
               exp = wrQ.pop_front();
               checkOutput("we_addr", {25'd0, regAddr}, {25'd0, exp[AW+DW-1:DW]});
               checkOutput("we_data", {16'd0, regWdata}, {16'd0, exp[DW-1:0]});
            end
         end
         if (txValid) begin
            if (rdQ.size() == 0) begin
               checkOutput("tx_valid_unexpected", {31'd0, txValid}, 32'd0);
            end else begin
               logic [DW-1:0] expRd;
               expRd = rdQ.pop_front();
               checkOutput("tx_data", {16'd0, txData}, {16'd0, expRd});
            end
         end
         if (late) begin
            if (lateQ.size() == 0) begin
               checkOutput("late_unexpected", {31'd0, late}, 32'd0);
            end else begin
               void'(lateQ.pop_front());
               checkOutput("late_re_held", {31'd0, regRe}, 32'd1);
            end
         end
      end
   end

   initial begin
      int reStart;
      rst_n       = 1'b0;
      spiSelected = 1'b0;
      rxEvent     = 1'b0;
      rxData      = '0;
      regRdata    = '0;
      regRvalid   = 1'b0;

      // Reset values.
      repeat (3) begin
         @(posedge clk); #1;
      end
      checkOutput("rst_tx_data", {16'd0, txData}, 32'd0);
      checkOutput("rst_tx_valid", {31'd0, txValid}, 32'd0);
      checkOutput("rst_addr", {25'd0, regAddr}, 32'd0);
      checkOutput("rst_wdata", {16'd0, regWdata}, 32'd0);
      checkOutput("rst_we", {31'd0, regWe}, 32'd0);
      checkOutput("rst_re", {31'd0, regRe}, 32'd0);
      checkOutput("rst_late", {31'd0, late}, 32'd0);
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end

      // Single write to address 5.
      selectFrame();
      applyStimulus(16'h0005, 6);
      wrQ.push_back({7'h05, 16'hBEEF});
      applyStimulus(16'hBEEF, 0);
      checkOutput("wr_we_latency", {31'd0, regWe}, 32'd1);
      repeat (6) begin
         @(posedge clk); #1;
      end
      endFrame();

      // Read from address 3, bus acknowledges in the second request cycle.
      selectFrame();
      reStart = reHighTotal;
      applyStimulus(16'h8003, 0);
      checkOutput("rd_re_latency", {31'd0, regRe}, 32'd1);
      checkOutput("rd_addr", {25'd0, regAddr}, 32'd3);
      @(posedge clk); #1;
      rdQ.push_back(16'h1234);
      regRdata  = 16'h1234;
      regRvalid = 1'b1;
      @(posedge clk); #1;
      regRvalid = 1'b0;
      checkOutput("rd_tx_valid_latency", {31'd0, txValid}, 32'd1);
      checkOutput("rd_re_dropped", {31'd0, regRe}, 32'd0);
      @(posedge clk); #1;
      checkOutput("rd_re_cycles", reHighTotal - reStart, 32'd2);
      applyStimulus(16'h0000, 6);
      endFrame();

      // Write burst starting at the top address.
      selectFrame();
      applyStimulus(16'h007F, 6);
      wrQ.push_back({7'h7F, 16'h0001});
`ifdef SPI_REG_CTRL_AUTOINC_EN
      wrQ.push_back({7'h00, 16'h0002});
      wrQ.push_back({7'h01, 16'h0003});
`endif
      applyStimulus(16'h0001, 6);
      applyStimulus(16'h0002, 6);
      applyStimulus(16'h0003, 6);
      endFrame();

      // Late read: host finishes a word before the data arrives.
      selectFrame();
      applyStimulus(16'h8010, 0);
      waitForRe();
      lateQ.push_back(1'b1);
      applyStimulus(16'hAAAA, 2);
      rdQ.push_back(16'h5678);
      regRdata  = 16'h5678;
      regRvalid = 1'b1;
      @(posedge clk); #1;
      regRvalid = 1'b0;
      applyStimulus(16'h0000, 4);
      endFrame();

      // Abort during a read request; a later acknowledge must be ignored.
      selectFrame();
      applyStimulus(16'h8020, 0);
      waitForRe();
      spiSelected = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_rd_re", {31'd0, regRe}, 32'd0);
      regRdata  = 16'hDEAD;
      regRvalid = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      regRvalid = 1'b0;
      endFrame();

      // Abort in the same cycle as the data word of a write.
      selectFrame();
      applyStimulus(16'h0030, 4);
      rxData      = 16'h9999;
      rxEvent     = 1'b1;
      spiSelected = 1'b0;
      @(posedge clk); #1;
      rxEvent = 1'b0;
      checkOutput("abort_wr_we", {31'd0, regWe}, 32'd0);
      endFrame();

      // Asynchronous reset while a read is outstanding.
      selectFrame();
      applyStimulus(16'h8040, 0);
      waitForRe();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_re", {31'd0, regRe}, 32'd0);
      checkOutput("arst_addr", {25'd0, regAddr}, 32'd0);
      checkOutput("arst_tx_data", {16'd0, txData}, 32'd0);
      checkOutput("arst_wdata", {16'd0, regWdata}, 32'd0);
      spiSelected = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Normal frame after the reset.
      selectFrame();
      applyStimulus(16'h0041, 6);
      wrQ.push_back({7'h41, 16'h4242});
      applyStimulus(16'h4242, 6);
      endFrame();

      repeat (10) begin
         @(posedge clk); #1;
      end
      checkOutput("wr_queue_drained", wrQ.size(), 32'd0);
      checkOutput("rd_queue_drained", rdQ.size(), 32'd0);
      checkOutput("late_queue_drained", lateQ.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
